// File: rtl/anim_pkg.sv
// Sprite animation sequencer shared types, sizing defaults and the per-state
// animation table (rows indexed by anim_state_t).
package anim_pkg;

  localparam int unsigned ANIM_NUM_STATES = 8;
  localparam int unsigned ANIM_MAX_FRAMES = 8;
  localparam int unsigned ANIM_HOLD_W     = 6;
  localparam int unsigned ANIM_SPRITE_W   = 32;
  localparam int unsigned ANIM_SPRITE_H   = 32;
  localparam int unsigned ANIM_OFS_W      = 10;
  localparam int unsigned ANIM_CNT_W      = 4;
  localparam int unsigned ANIM_ROW_IDX_W  = $clog2(ANIM_NUM_STATES);
  localparam int unsigned ANIM_FRM_IDX_W  = $clog2(ANIM_MAX_FRAMES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WALK   = 3'd1,
    ST_RUN    = 3'd2,
    ST_ATTACK = 3'd3,
    ST_JUMP   = 3'd4,
    ST_HURT   = 3'd5,
    ST_DIE    = 3'd6,
    ST_CAST   = 3'd7
  } anim_state_t;

  typedef enum logic {
    PH_PLAYING  = 1'b0,
    PH_FINISHED = 1'b1
  } phase_t;

  typedef struct packed {
    logic [ANIM_CNT_W-1:0]                       n_frames;
    logic [ANIM_MAX_FRAMES-1:0][ANIM_HOLD_W-1:0] hold;
    logic                                        loop;
    logic                                        interruptible;
    logic [ANIM_CNT_W-1:0]                       hb_first;
    logic [ANIM_CNT_W-1:0]                       hb_last;
  } anim_row_t;

  // hb_first > hb_last encodes "no hitbox in this animation"
  localparam logic [ANIM_CNT_W-1:0] HB_NONE_FIRST = 4'hF;
  localparam logic [ANIM_CNT_W-1:0] HB_NONE_LAST  = 4'h0;

  localparam anim_row_t ANIM_TABLE [ANIM_NUM_STATES] = '{
    '{n_frames: 4'd4, hold: {ANIM_MAX_FRAMES{6'd3}}, loop: 1'b1, interruptible: 1'b1,
      hb_first: HB_NONE_FIRST, hb_last: HB_NONE_LAST},
    '{n_frames: 4'd6, hold: {ANIM_MAX_FRAMES{6'd2}}, loop: 1'b1, interruptible: 1'b1,
      hb_first: HB_NONE_FIRST, hb_last: HB_NONE_LAST},
    '{n_frames: 4'd8, hold: {ANIM_MAX_FRAMES{6'd1}}, loop: 1'b1, interruptible: 1'b1,
      hb_first: HB_NONE_FIRST, hb_last: HB_NONE_LAST},
    '{n_frames: 4'd5, hold: {ANIM_MAX_FRAMES{6'd2}}, loop: 1'b0, interruptible: 1'b0,
      hb_first: 4'd2, hb_last: 4'd3},
    '{n_frames: 4'd6, hold: {6'd2, 6'd2, 6'd4, 6'd4, 6'd4, 6'd3, 6'd3, 6'd2},
      loop: 1'b0, interruptible: 1'b1, hb_first: HB_NONE_FIRST, hb_last: HB_NONE_LAST},
    '{n_frames: 4'd3, hold: {ANIM_MAX_FRAMES{6'd2}}, loop: 1'b0, interruptible: 1'b0,
      hb_first: HB_NONE_FIRST, hb_last: HB_NONE_LAST},
    '{n_frames: 4'd8, hold: {ANIM_MAX_FRAMES{6'd5}}, loop: 1'b0, interruptible: 1'b0,
      hb_first: HB_NONE_FIRST, hb_last: HB_NONE_LAST},
    '{n_frames: 4'd4, hold: {ANIM_MAX_FRAMES{6'd0}}, loop: 1'b0, interruptible: 1'b1,
      hb_first: 4'd1, hb_last: 4'd3}
  };

endpackage

// File: rtl/anim_table.sv
// Combinational animation table lookup: (state, frame) -> row attributes and
// the hold count of that frame.
module anim_table
  import anim_pkg::*;
#(
  parameter int unsigned STATE_W = 3,
  parameter int unsigned FRAME_W = 3,
  parameter int unsigned HOLD_W  = 6
) (
  input  logic [STATE_W-1:0] state,
  input  logic [FRAME_W-1:0] frame,
  output logic [FRAME_W:0]   n_frames,
  output logic [HOLD_W-1:0]  hold,
  output logic               loop,
  output logic               interruptible,
  output logic [FRAME_W:0]   hb_first,
  output logic [FRAME_W:0]   hb_last
);

  localparam int unsigned NW = FRAME_W + 1;

  anim_row_t row;

  always_comb begin
    row = ANIM_TABLE[0];
    for (int unsigned i = 0; i < ANIM_NUM_STATES; i++) begin
      if (32'(state) == i) row = ANIM_TABLE[ANIM_ROW_IDX_W'(i)];
    end

    hold = '0;
    for (int unsigned j = 0; j < ANIM_MAX_FRAMES; j++) begin
      if (32'(frame) == j) hold = HOLD_W'(row.hold[ANIM_FRM_IDX_W'(j)]);
    end

    n_frames      = NW'(row.n_frames);
    loop          = row.loop;
    interruptible = row.interruptible;
    hb_first      = NW'(row.hb_first);
    hb_last       = NW'(row.hb_last);
  end

endmodule

// File: rtl/anim_sequencer.sv
// Sprite animation sequencer: steps through per-state frame tables on frame
// ticks, handles one-shot/looping and non-interruptible animations.
module anim_sequencer
  import anim_pkg::*;
#(
  parameter  int unsigned NUM_STATES = 8,
  parameter  int unsigned MAX_FRAMES = 8,
  parameter  int unsigned HOLD_W     = 6,
  parameter  int unsigned SPRITE_W   = 32,
  parameter  int unsigned SPRITE_H   = 32,
  parameter  int unsigned OFS_W      = 10,
  localparam int unsigned STATE_W    = $clog2(NUM_STATES),
  localparam int unsigned FRAME_W    = $clog2(MAX_FRAMES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [STATE_W-1:0] anim_state,
  input  logic               restart,
  output logic [STATE_W-1:0] cur_state,
  output logic [FRAME_W-1:0] anim_frame,
  output logic [OFS_W-1:0]   x_offset,
  output logic [OFS_W-1:0]   y_offset,
  output logic               hitbox_active,
  output logic               anim_done,
  output logic               locked
);

  localparam int unsigned NW = FRAME_W + 1;

  if (NUM_STATES > ANIM_NUM_STATES || MAX_FRAMES > ANIM_MAX_FRAMES) begin : g_bad_table
    $error("anim_sequencer: NUM_STATES/MAX_FRAMES exceed the animation table");
  end
  if ((MAX_FRAMES - 1) * SPRITE_W >= 2**OFS_W ||
      (NUM_STATES - 1) * SPRITE_H >= 2**OFS_W) begin : g_bad_ofs
    $error("anim_sequencer: sprite-sheet offsets do not fit in OFS_W");
  end

  logic [HOLD_W-1:0]  hold_cnt, nxt_hold_cnt;
  phase_t             phase, nxt_phase;
  logic [STATE_W-1:0] nxt_state;
  logic [FRAME_W-1:0] nxt_frame;
  logic               nxt_done, nxt_locked;

  logic [NW-1:0]      cur_n_frames, cur_hb_first, cur_hb_last;
  logic [HOLD_W-1:0]  cur_hold, hold_last;
  logic               cur_loop, cur_interruptible;
  logic               req_interruptible, req_valid, do_switch, last_frame;

  logic [NW-1:0]      unused_req_n_frames, unused_req_hb_first, unused_req_hb_last;
  logic [HOLD_W-1:0]  unused_req_hold;
  logic               unused_req_loop, unused_cur_interruptible;

  anim_table #(.STATE_W(STATE_W), .FRAME_W(FRAME_W), .HOLD_W(HOLD_W)) u_cur (
    .state        (cur_state),
    .frame        (anim_frame),
    .n_frames     (cur_n_frames),
    .hold         (cur_hold),
    .loop         (cur_loop),
    .interruptible(cur_interruptible),
    .hb_first     (cur_hb_first),
    .hb_last      (cur_hb_last)
  );

  // Second lookup only supplies the requested row's lock attribute at switch time.
  anim_table #(.STATE_W(STATE_W), .FRAME_W(FRAME_W), .HOLD_W(HOLD_W)) u_req (
    .state        (anim_state),
    .frame        ('0),
    .n_frames     (unused_req_n_frames),
    .hold         (unused_req_hold),
    .loop         (unused_req_loop),
    .interruptible(req_interruptible),
    .hb_first     (unused_req_hb_first),
    .hb_last      (unused_req_hb_last)
  );

  assign unused_cur_interruptible = cur_interruptible;

  if (NUM_STATES == 2**STATE_W) begin : g_req_full
    assign req_valid = 1'b1;
  end else begin : g_req_range
    assign req_valid = (anim_state < STATE_W'(NUM_STATES));
  end

  assign do_switch  = ~locked & req_valid & ((anim_state != cur_state) | restart);
  assign hold_last  = (cur_hold == '0) ? '0 : cur_hold - HOLD_W'(1);
  assign last_frame = ({1'b0, anim_frame} == cur_n_frames - NW'(1));

  always_comb begin
    nxt_state    = cur_state;
    nxt_frame    = anim_frame;
    nxt_hold_cnt = hold_cnt;
    nxt_phase    = phase;
    nxt_locked   = locked;
    nxt_done     = 1'b0;
    if (frame_tick) begin
      if (do_switch) begin
        nxt_state    = anim_state;
        nxt_frame    = '0;
        nxt_hold_cnt = '0;
        nxt_phase    = PH_PLAYING;
        nxt_locked   = ~req_interruptible;
      end else if (phase == PH_PLAYING) begin
        if (hold_cnt == hold_last) begin
          nxt_hold_cnt = '0;
          if (last_frame) begin
            nxt_done = 1'b1;
            if (cur_loop) begin
              nxt_frame = '0;
            end else begin
              nxt_phase  = PH_FINISHED;
              nxt_locked = 1'b0;
            end
          end else begin
            nxt_frame = anim_frame + FRAME_W'(1);
          end
        end else begin
          nxt_hold_cnt = hold_cnt + HOLD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state  <= STATE_W'(ST_IDLE);
      anim_frame <= '0;
      hold_cnt   <= '0;
      phase      <= PH_PLAYING;
      anim_done  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      anim_frame <= nxt_frame;
      hold_cnt   <= nxt_hold_cnt;
      phase      <= nxt_phase;
      anim_done  <= nxt_done;
      locked     <= nxt_locked;
    end
  end

  assign x_offset      = OFS_W'(32'(anim_frame) * SPRITE_W);
  assign y_offset      = OFS_W'(32'(cur_state) * SPRITE_H);
  assign hitbox_active = ({1'b0, anim_frame} >= cur_hb_first) &&
                         ({1'b0, anim_frame} <= cur_hb_last);

endmodule

// File: tb/tb_anim_sequencer.sv
// Scoreboard bench for anim_sequencer: stimulus queues hand-computed expected
// outputs per frame tick; the monitor compares one clk after each tick edge.
module tb_anim_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic       restart = 1'b0;
  logic [2:0] anim_state = 3'd0;
  logic [2:0] cur_state, anim_frame;
  logic [9:0] x_offset, y_offset;
  logic       hitbox_active, anim_done, locked;

  always #5 clk = ~clk;

  // NUM_STATES=6 leaves codes 6 and 7 representable but out of range.
  anim_sequencer #(.NUM_STATES(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .anim_state   (anim_state),
    .restart      (restart),
    .cur_state    (cur_state),
    .anim_frame   (anim_frame),
    .x_offset     (x_offset),
    .y_offset     (y_offset),
    .hitbox_active(hitbox_active),
    .anim_done    (anim_done),
    .locked       (locked)
  );

  typedef struct {
    int         id;
    logic [2:0] st;
    logic [2:0] fr;
    logic       done;
    logic       lock;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   tick_id = 0;

  // Only ATTACK (state 3) has a hitbox among the states this bench plays: frames 2..3.
  function automatic logic [28:0] expect_word(input logic [2:0] st, input logic [2:0] fr,
                                              input logic done, input logic lock);
    logic [9:0] x, y;
    logic       hb;
    x  = {2'b00, fr, 5'b00000};
    y  = {2'b00, st, 5'b00000};
    hb = (st == 3'd3) && (fr >= 3'd2) && (fr <= 3'd3);
    return {st, fr, x, y, hb, done, lock};
  endfunction

  function automatic logic [28:0] dut_word();
    return {cur_state, anim_frame, x_offset, y_offset, hitbox_active, anim_done, locked};
  endfunction

  task automatic compare(input string name, input logic [28:0] act, input logic [28:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got st=%0d fr=%0d x=%0d y=%0d hb=%0b done=%0b lock=%0b, want st=%0d fr=%0d x=%0d y=%0d hb=%0b done=%0b lock=%0b",
               name, act[28:26], act[25:23], act[22:13], act[12:3], act[2], act[1], act[0],
               exp[28:26], exp[25:23], exp[22:13], exp[12:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic tick(input logic [2:0] as, input logic rs, input logic [2:0] es,
                      input logic [2:0] ef, input logic ed, input logic el);
    exp_t e;
    @(negedge clk);
    anim_state = as;
    restart    = rs;
    frame_tick = 1'b1;
    tick_id++;
    e.id = tick_id; e.st = es; e.fr = ef; e.done = ed; e.lock = el;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    frame_tick = 1'b0;
    restart    = 1'b0;
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    if (rst_n && frame_tick) begin
      #1;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL tick_unexpected: got an output with no queued expectation, want none");
      end else begin
        e = exp_q.pop_front();
        compare($sformatf("tick%0d", e.id), dut_word(), expect_word(e.st, e.fr, e.done, e.lock));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1);
  end

  initial begin : stimulus
    int changed;

    #2 rst_n = 1'b0;
    #1 compare("reset", dut_word(), expect_word(3'd0, 3'd0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE: 4 frames x hold 3, looping; done on the 12th tick
    for (int k = 1; k <= 12; k++)
      tick(3'd0, 1'b0, 3'd0, 3'((k / 3) % 4), (k == 12), 1'b0);
    idle_cycle();
    @(posedge clk);
    #1 compare("done_one_clk", dut_word(), expect_word(3'd0, 3'd0, 1'b0, 1'b0));

    // IDLE to frame 2 (hold_cnt 1), then restart; hold_cnt must restart at 0
    tick(3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    tick(3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    tick(3'd0, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0);
    tick(3'd0, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0);
    tick(3'd0, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0);
    tick(3'd0, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0);
    tick(3'd0, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0);
    tick(3'd0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
    tick(3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    tick(3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    tick(3'd0, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0);
    // out-of-range requests are ignored, with or without restart
    tick(3'd7, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0);
    tick(3'd7, 1'b1, 3'd0, 3'd1, 1'b0, 1'b0);
    tick(3'd0, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0);
    tick(3'd6, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0);

    // ATTACK: 5 frames x hold 2, one-shot, locked; requests during lock ignored
    tick(3'd3, 1'b0, 3'd3, 3'd0, 1'b0, 1'b1);
    tick(3'd3, 1'b0, 3'd3, 3'd0, 1'b0, 1'b1);
    tick(3'd3, 1'b0, 3'd3, 3'd1, 1'b0, 1'b1);
    tick(3'd0, 1'b1, 3'd3, 3'd1, 1'b0, 1'b1);
    tick(3'd0, 1'b1, 3'd3, 3'd2, 1'b0, 1'b1);
    tick(3'd3, 1'b0, 3'd3, 3'd2, 1'b0, 1'b1);
    tick(3'd3, 1'b0, 3'd3, 3'd3, 1'b0, 1'b1);
    tick(3'd3, 1'b0, 3'd3, 3'd3, 1'b0, 1'b1);
    tick(3'd3, 1'b0, 3'd3, 3'd4, 1'b0, 1'b1);
    tick(3'd3, 1'b0, 3'd3, 3'd4, 1'b0, 1'b1);
    tick(3'd3, 1'b0, 3'd3, 3'd4, 1'b1, 1'b0);
    tick(3'd3, 1'b0, 3'd3, 3'd4, 1'b0, 1'b0);
    tick(3'd3, 1'b0, 3'd3, 3'd4, 1'b0, 1'b0);
    tick(3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);

    // re-enter ATTACK, run to frame 3, then reset asynchronously
    tick(3'd3, 1'b0, 3'd3, 3'd0, 1'b0, 1'b1);
    tick(3'd3, 1'b0, 3'd3, 3'd0, 1'b0, 1'b1);
    tick(3'd3, 1'b0, 3'd3, 3'd1, 1'b0, 1'b1);
    tick(3'd3, 1'b0, 3'd3, 3'd1, 1'b0, 1'b1);
    tick(3'd3, 1'b0, 3'd3, 3'd2, 1'b0, 1'b1);
    tick(3'd3, 1'b0, 3'd3, 3'd2, 1'b0, 1'b1);
    tick(3'd3, 1'b0, 3'd3, 3'd3, 1'b0, 1'b1);
    idle_cycle();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 compare("async_reset", dut_word(), expect_word(3'd0, 3'd0, 1'b0, 1'b0));
    @(negedge clk);
    anim_state = 3'd3;
    rst_n = 1'b1;

    changed = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (dut_word() !== expect_word(3'd0, 3'd0, 1'b0, 1'b0)) changed++;
    end
    n_vec++;
    if (changed != 0) begin
      n_bad++;
      $display("FAIL no_tick_stable: got %0d cycles with changed outputs, want 0", changed);
    end
    compare("no_tick_end", dut_word(), expect_word(3'd0, 3'd0, 1'b0, 1'b0));

    // after reset: HURT (state 5) locks, restart to IDLE ignored
    tick(3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    tick(3'd5, 1'b0, 3'd5, 3'd0, 1'b0, 1'b1);
    tick(3'd0, 1'b1, 3'd5, 3'd0, 1'b0, 1'b1);
    tick(3'd0, 1'b0, 3'd5, 3'd1, 1'b0, 1'b1);
    idle_cycle();
    repeat (3) @(posedge clk);
    #1;

    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drained: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
